// File: rtl/ltc2308_ctrl.sv
// ---------------------------------------------------------------------------
// ltc2308_ctrl
//
// Transaction controller for an LTC2308 12-bit SAR ADC. One accepted start
// request produces one complete conversion cycle:
//   CONVST    : pulse adc_convst high to begin the conversion
//   CONV_WAIT : hold the bus quiet while the ADC converts; adc_sdi already
//               carries the first config bit
//   SHIFT     : 12 SCK periods. Config bits are shifted out on adc_sdi and
//               result bits are shifted in from adc_sdo, MSB first.
//   DONE      : publish the result on data and pulse done for one cycle
//
// Every output is a flop. The combinational block computes the value each
// output should take for the current state, and the flops present it one
// cycle later. Because all outputs share that one-cycle lag, SCK and SDI stay
// phase-aligned with each other and with adc_convst.
//
// Parameters
//   CONVST_CYCLES : adc_convst high time in clk cycles (>= 1)
//   CONV_CYCLES   : conversion wait before the first SCK, in clk cycles (>= 1)
//   SCK_HALF      : SCK half-period in clk cycles (>= 1)
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   conversion request, only honoured in IDLE
//   cfg        in   6   {S/D, O/S, S1, S0, UNI, SLP}, latched on acceptance
//   busy       out  1   transaction in progress
//   done       out  1   one-cycle pulse when data is updated
//   data       out  12  last completed conversion result
//   adc_convst out  1   ADC conversion start
//   adc_sck    out  1   ADC serial clock
//   adc_sdi    out  1   config bits to the ADC
//   adc_sdo    in   1   result bits from the ADC
// ---------------------------------------------------------------------------
module ltc2308_ctrl #(
    parameter int CONVST_CYCLES = 4,
    parameter int CONV_CYCLES   = 80,
    parameter int SCK_HALF      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cfg,
    output logic        busy,
    output logic        done,
    output logic [11:0] data,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo
);

    // One shared cycle counter covers the CONVST, CONV_WAIT and half-period
    // timing, so it is sized for the largest of the three intervals.
    localparam int MAX_AB = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
    localparam int MAX_CNT = (MAX_AB > SCK_HALF) ? MAX_AB : SCK_HALF;
    localparam int CW = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CW-1:0] CONVST_LAST = CW'(CONVST_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(SCK_HALF - 1);
    localparam logic [CW-1:0] CNT_ZERO    = '0;
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [3:0]    BIT_LAST    = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONVST    = 3'd1,
        S_CONV_WAIT = 3'd2,
        S_SHIFT     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    // Config bit presented during SCK period idx+1. The first six periods carry
    // cfg[5] down to cfg[0]; the remaining periods carry 0.
    function automatic logic cfg_bit(input logic [5:0] c, input logic [3:0] idx);
        logic b;
        case (idx)
            4'd0:    b = c[5];
            4'd1:    b = c[4];
            4'd2:    b = c[3];
            4'd3:    b = c[2];
            4'd4:    b = c[1];
            4'd5:    b = c[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // State and datapath registers
    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            phase_r;     // 0 = SCK low half, 1 = SCK high half
    logic [3:0]      bit_r;       // current SCK period, 0..11
    logic [5:0]      cfg_r;
    logic [11:0]     shift_r;
    logic [11:0]     data_r;
    logic            busy_r;
    logic            done_r;
    logic            convst_r;
    logic            sck_r;
    logic            sdi_r;

    // Next-state and next-output values
    state_t          state_s;
    logic [CW-1:0]   cnt_s;
    logic            phase_s;
    logic [3:0]      bit_s;
    logic            accept_s;
    logic            busy_s;
    logic            done_s;
    logic            convst_s;
    logic            sck_s;
    logic            sdi_s;
    logic            sample_s;

    // Next-state logic: sequencing of states, cycle counter, SCK phase and bit count
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        phase_s  = phase_r;
        bit_s    = bit_r;
        accept_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    state_s  = S_CONVST;
                    cnt_s    = CNT_ZERO;
                end else begin
                    state_s  = S_IDLE;
                end
            end
            S_CONVST: begin
                if (cnt_r == CONVST_LAST) begin
                    state_s = S_CONV_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            S_CONV_WAIT: begin
                if (cnt_r == CONV_LAST) begin
                    state_s = S_SHIFT;
                    cnt_s   = CNT_ZERO;
                    phase_s = 1'b0;
                    bit_s   = 4'd0;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            S_SHIFT: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (!phase_r) begin
                        phase_s = 1'b1;
                    end else begin
                        phase_s = 1'b0;
                        // The bit counter stops at 11; leaving SHIFT ends the frame.
                        if (bit_r == BIT_LAST) begin
                            state_s = S_DONE;
                        end else begin
                            bit_s = bit_r + 4'd1;
                        end
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
                phase_s = 1'b0;
                bit_s   = 4'd0;
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
                phase_s = 1'b0;
                bit_s   = 4'd0;
            end
        endcase
    end

    // Output decode: the value each output flop takes for the current state
    always_comb begin
        convst_s = 1'b0;
        sck_s    = 1'b0;
        sdi_s    = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            S_CONVST: begin
                convst_s = 1'b1;
            end
            S_CONV_WAIT: begin
                sdi_s = cfg_r[5];
            end
            S_SHIFT: begin
                sck_s = phase_r;
                sdi_s = cfg_bit(cfg_r, bit_r);
            end
            S_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                convst_s = 1'b0;
            end
        endcase
        // busy rises on the accepting edge and falls only when the FSM settles
        // back in IDLE, so it overlaps the done pulse.
        busy_s = accept_s | (state_r != S_IDLE);
        // The edge that drives adc_sck 0->1 is also the edge that samples adc_sdo.
        sample_s = sck_s & ~sck_r;
    end

    // State, datapath and registered outputs, with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= S_IDLE;
            cnt_r    <= CNT_ZERO;
            phase_r  <= 1'b0;
            bit_r    <= 4'd0;
            cfg_r    <= 6'd0;
            shift_r  <= 12'd0;
            data_r   <= 12'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            convst_r <= 1'b0;
            sck_r    <= 1'b0;
            sdi_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            phase_r  <= phase_s;
            bit_r    <= bit_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            convst_r <= convst_s;
            sck_r    <= sck_s;
            sdi_r    <= sdi_s;
            if (accept_s) begin
                cfg_r <= cfg;
            end
            if (sample_s) begin
                shift_r <= {shift_r[10:0], adc_sdo};
            end
            if (state_r == S_DONE) begin
                data_r <= shift_r;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign data       = data_r;
    assign adc_convst = convst_r;
    assign adc_sck    = sck_r;
    assign adc_sdi    = sdi_r;

endmodule
